ps2_keycode_rx: RTL and testbench

- Receives PS/2 keyboard frames (scan code set 2) and converts make/break sequences into an 8-bit USB-HID usage keycode.
- Drives the same `keycode` bus that the game-state logic and the motion logic consume, so a PS/2 keyboard can replace the USB/NIOS keycode path.
- Holds the keycode of the most recently pressed mapped key and returns it to 0 on that key's release.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_to_hid.sv | 29 ++
 rtl/ps2_keycode_rx.sv | 141 ++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code-set-2 keyboard receiver.
// Covers the frame FSM states, the prefix bytes, the scan codes and the HID usages.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Set-2 scan codes of the keys the game cares about (arrows need the E0 prefix)
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_ESC   = 8'd41;
  localparam logic [7:0] HID_ENTER = 8'd40;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;

  // PS/2 uses odd parity: data plus parity bit must contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_to_hid.sv
// Combinational translation of {extended-prefix flag, set-2 scan code} to a HID usage.
// Any code that is not in the table maps to 0.
module ps2_to_hid
  import ps2_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic [7:0] hid
);

  always_comb begin
    hid = HID_NONE;
    case ({ext, code})
      {1'b0, SC_ESC}:   hid = HID_ESC;
      {1'b0, SC_ENTER}: hid = HID_ENTER;
      {1'b0, SC_SPACE}: hid = HID_SPACE;
      {1'b0, SC_W}:     hid = HID_W;
      {1'b0, SC_A}:     hid = HID_A;
      {1'b0, SC_S}:     hid = HID_S;
      {1'b0, SC_D}:     hid = HID_D;
      {1'b1, SC_UP}:    hid = HID_UP;
      {1'b1, SC_DOWN}:  hid = HID_DOWN;
      {1'b1, SC_LEFT}:  hid = HID_LEFT;
      {1'b1, SC_RIGHT}: hid = HID_RIGHT;
      default:          hid = HID_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronises the bus, deframes bytes and turns make/break
// sequences into the HID keycode of the most recently pressed mapped key.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic         clk_s1, clk_s2, clk_prev;
  logic         data_s1, data_s2, data_d;
  logic         fall;
  frame_state_t state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shift;
  logic         par;
  logic [TW-1:0] to_cnt;
  logic         byte_valid;
  logic [7:0]   rx_byte;
  logic         ext, brk;
  logic [7:0]   hid;

  // Flops preset to 1 so reset never fabricates a falling edge on an idle bus
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      data_d   <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      data_d   <= data_s2;
      fall     <= clk_prev & ~clk_s2;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // An edge always wins over a timeout expiring in the same cycle
      if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_d) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {data_d, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_d;
            state <= STOP;
          end
          STOP: begin
            if (data_d && odd_parity_ok(shift, par)) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
          bit_cnt   <= '0;
          shift     <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  ps2_to_hid u_to_hid (
    .ext  (ext),
    .code (rx_byte),
    .hid  (hid)
  );

  // Prefix flags accumulate until a non-prefix byte consumes them
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      keycode <= '0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext <= 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (hid != HID_NONE) begin
          if (!brk)                keycode <= hid;
          else if (hid == keycode) keycode <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table-driven key sequences, framing corner cases and
// random byte streams checked against a make/break reference model.
module tb_ps2_keycode_rx;

  localparam int TO  = 300;
  localparam int H   = 8;
  localparam int GAP = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int err_long = 0;
  logic err_prev = 1'b0;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (frame_err === 1'b1 && err_prev === 1'b1) err_long++;
    err_prev = frame_err;
  end

  typedef struct {
    logic [7:0] code;
    logic [7:0] kc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] code, input int i, input logic bad_par);
    if (i == 0) return 1'b0;
    if (i <= 8) return code[i-1];
    if (i == 9) return (~^code) ^ bad_par;
    return 1'b1;
  endfunction

  task automatic drive_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] code, input logic bad_par, input int from, input int to);
    for (int i = from; i <= to; i++) drive_bit(frame_bit(code, i, bad_par));
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    send_bits(code, bad_par, 0, 10);
    repeat (GAP) @(negedge Clk);
    $display("tx byte=%h bad_par=%0d keycode=%h", code, bad_par, keycode);
  endtask

  function automatic logic [7:0] ref_hid(input logic ext, input logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h76: return 8'd41;
        8'h5A: return 8'd40;
        8'h29: return 8'h2C;
        8'h1D: return 8'h1A;
        8'h1C: return 8'h04;
        8'h1B: return 8'h16;
        8'h23: return 8'h07;
        default: return 8'h00;
      endcase
    end
    case (c)
      8'h75: return 8'h52;
      8'h72: return 8'h51;
      8'h6B: return 8'h50;
      8'h74: return 8'h4F;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] pool [16];

  initial begin
    logic [7:0] m_kc;
    logic       m_ext, m_brk;
    logic [7:0] c, h;
    int         e0;

    Reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge Clk);
    check("reset_keycode", keycode, 8'h00);
    check("reset_frame_err", {7'b0, frame_err}, 8'h00);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    // Esc press with exact latency from the stop-bit clock edge
    send_bits(8'h76, 1'b0, 0, 9);
    ps2_data = 1'b1;
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1 check("esc_latency_early", keycode, 8'h00);
    @(posedge Clk);
    #1 check("esc_latency_on_time", keycode, 8'd41);
    @(negedge Clk);
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge Clk);

    vecs = '{};
    vecs.push_back('{8'hF0, 8'd41}); vecs.push_back('{8'h76, 8'h00});
    vecs.push_back('{8'hE0, 8'h00}); vecs.push_back('{8'h75, 8'h52});
    vecs.push_back('{8'hE0, 8'h52}); vecs.push_back('{8'hF0, 8'h52});
    vecs.push_back('{8'h75, 8'h00}); vecs.push_back('{8'h5A, 8'd40});
    vecs.push_back('{8'h1C, 8'h04}); vecs.push_back('{8'hF0, 8'h04});
    vecs.push_back('{8'h5A, 8'h04}); vecs.push_back('{8'hF0, 8'h04});
    vecs.push_back('{8'h1C, 8'h00}); vecs.push_back('{8'h29, 8'h2C});
    vecs.push_back('{8'h1D, 8'h1A}); vecs.push_back('{8'hF0, 8'h1A});
    vecs.push_back('{8'h29, 8'h1A}); vecs.push_back('{8'hF0, 8'h1A});
    vecs.push_back('{8'h1D, 8'h00}); vecs.push_back('{8'h1B, 8'h16});
    vecs.push_back('{8'h23, 8'h07}); vecs.push_back('{8'hE0, 8'h07});
    vecs.push_back('{8'h72, 8'h51}); vecs.push_back('{8'hE0, 8'h51});
    vecs.push_back('{8'h6B, 8'h50}); vecs.push_back('{8'hE0, 8'h50});
    vecs.push_back('{8'h74, 8'h4F}); vecs.push_back('{8'h72, 8'h4F});
    vecs.push_back('{8'h75, 8'h4F}); vecs.push_back('{8'hE0, 8'h4F});
    vecs.push_back('{8'hF0, 8'h4F}); vecs.push_back('{8'h74, 8'h00});
    vecs.push_back('{8'h74, 8'h00}); vecs.push_back('{8'h1C, 8'h04});
    vecs.push_back('{8'h1C, 8'h04}); vecs.push_back('{8'hF0, 8'h04});
    vecs.push_back('{8'h1C, 8'h00});
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].code, 1'b0);
      check($sformatf("table_%0d_%h", i, vecs[i].code), keycode, vecs[i].kc);
    end
    check("table_no_frame_err", 8'(err_pulses), 8'h00);

    // Bad parity: one error pulse, keycode untouched, next frame fine
    e0 = err_pulses;
    send_frame(8'h76, 1'b1);
    check("badpar_err_count", 8'(err_pulses - e0), 8'h01);
    check("badpar_keycode", keycode, 8'h00);
    send_frame(8'h76, 1'b0);
    check("after_badpar_press", keycode, 8'd41);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h76, 1'b0);
    check("after_badpar_release", keycode, 8'h00);

    // Timeout after start bit plus 4 data bits
    e0 = err_pulses;
    send_bits(8'h5A, 1'b0, 0, 4);
    repeat (TO + 10) @(negedge Clk);
    check("timeout_err_count", 8'(err_pulses - e0), 8'h01);
    check("timeout_keycode", keycode, 8'h00);
    send_frame(8'h5A, 1'b0);
    check("after_timeout_enter", keycode, 8'd40);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check("after_timeout_release", keycode, 8'h00);

    // Random byte stream against the make/break model
    pool = '{8'h76, 8'h5A, 8'h29, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75,
             8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h00};
    m_kc = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    e0 = err_pulses;
    for (int n = 0; n < 70; n++) begin
      int idx;
      idx = int'($urandom_range(0, 15));
      c = (idx == 15) ? 8'($urandom_range(0, 255)) : pool[idx];
      if (c == 8'hE0) m_ext = 1'b1;
      else if (c == 8'hF0) m_brk = 1'b1;
      else begin
        h = ref_hid(m_ext, c);
        if (h != 8'h00) begin
          if (!m_brk) m_kc = h;
          else if (h == m_kc) m_kc = 8'h00;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      send_frame(c, 1'b0);
      check($sformatf("rand_%0d_%h", n, c), keycode, m_kc);
    end
    check("rand_no_frame_err", 8'(err_pulses - e0), 8'h00);

    // Reset in the middle of a frame while Esc is held
    send_frame(8'h00, 1'b0);
    send_frame(8'h76, 1'b0);
    check("pre_reset_esc", keycode, 8'd41);
    send_bits(8'h76, 1'b0, 0, 5);
    Reset = 1'b1;
    @(posedge Clk);
    #1 check("midframe_reset_keycode", keycode, 8'h00);
    @(negedge Clk);
    Reset = 1'b0;
    send_bits(8'h76, 1'b0, 6, 10);
    repeat (TO + 20) @(negedge Clk);
    check("after_reset_leftovers", keycode, 8'h00);
    send_frame(8'h29, 1'b0);
    check("after_reset_space", keycode, 8'h2C);

    check("frame_err_single_cycle", 8'(err_long), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
